// File: rtl/alu_packet_parser.sv
// Header/payload parser in front of the UART ALU: splits the RX byte stream into operand words or echo bytes.
// Optional mid-packet idle timeout is compiled in with `define PARSER_TIMEOUT_EN.
module alu_packet_parser #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           WORD_BYTES     = 4,
  parameter logic [DATA_WIDTH-1:0] ECHO_OPCODE    = 8'hEC,
  parameter int unsigned           TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_op_o,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] m_word_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic                           m_first_o,
  output logic                           m_last_o,
  output logic [DATA_WIDTH-1:0]          echo_tdata_o,
  output logic                           echo_tvalid_o,
  input  logic                           echo_tready_i,
  output logic                           err_o
);

  localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [15:0] WB16  = 16'(WORD_BYTES);
  localparam logic [15:0] HDR16 = 16'd4;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RESERVED,
    S_LEN_LSB,
    S_LEN_MSB,
    S_ECHO,
    S_COLLECT,
    S_OUT,
    S_DRAIN
  } state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   len_lsb;
  logic [15:0]             rem;
  logic [IDX_W-1:0]        byte_idx;
  logic                    err_n;
  logic                    s_xfer;
  logic                    timeout;

  logic [15:0] hdr_len;
  logic [15:0] payload;
  logic        op_echo;
  logic        op_alu;
  logic        alu_len_ok;

  assign hdr_len    = 16'({s_axis_tdata, len_lsb});
  assign payload    = hdr_len - HDR16;
  assign op_echo    = (m_op_o == ECHO_OPCODE);
  assign op_alu     = (m_op_o == DATA_WIDTH'(1)) || (m_op_o == DATA_WIDTH'(2)) ||
                      (m_op_o == DATA_WIDTH'(3));
  assign alu_len_ok = ((payload % WB16) == 16'd0) && (payload >= (WB16 << 1));
  assign s_xfer     = s_axis_tvalid && s_axis_tready;
  assign echo_tdata_o = s_axis_tdata;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_OPCODE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    err_n         = 1'b0;
    s_axis_tready = 1'b0;
    echo_tvalid_o = 1'b0;
    m_valid_o     = 1'b0;
    case (state)
      S_OPCODE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = S_RESERVED;
      end
      S_RESERVED: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = S_LEN_LSB;
      end
      S_LEN_LSB: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = S_LEN_MSB;
      end
      S_LEN_MSB: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (hdr_len < HDR16) begin
            err_n   = 1'b1;
            state_n = S_OPCODE;
          end else if (op_echo) begin
            state_n = (payload == 16'd0) ? S_OPCODE : S_ECHO;
          end else if (op_alu && alu_len_ok) begin
            state_n = S_COLLECT;
          end else begin
            err_n   = 1'b1;
            state_n = (payload == 16'd0) ? S_OPCODE : S_DRAIN;
          end
        end
      end
      S_ECHO: begin
        s_axis_tready = echo_tready_i;
        echo_tvalid_o = s_axis_tvalid;
        if (s_axis_tvalid && echo_tready_i && rem <= 16'd1) state_n = S_OPCODE;
      end
      S_COLLECT: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && byte_idx == IDX_W'(WORD_BYTES - 1)) state_n = S_OUT;
      end
      S_OUT: begin
        m_valid_o = 1'b1;
        if (m_ready_i) state_n = m_last_o ? S_OPCODE : S_COLLECT;
      end
      S_DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && rem <= 16'd1) state_n = S_OPCODE;
      end
      default: state_n = S_OPCODE;
    endcase
    if (timeout) begin
      state_n = S_OPCODE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_op_o    <= '0;
      m_word_o  <= '0;
      len_lsb   <= '0;
      rem       <= '0;
      byte_idx  <= '0;
      m_first_o <= 1'b0;
      m_last_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      err_o <= err_n;
      if (s_xfer) begin
        case (state)
          S_OPCODE:  m_op_o  <= s_axis_tdata;
          S_LEN_LSB: len_lsb <= s_axis_tdata;
          S_LEN_MSB: begin
            rem       <= payload;
            byte_idx  <= '0;
            m_first_o <= 1'b1;
            m_last_o  <= 1'b0;
          end
          S_ECHO, S_DRAIN: begin
            if (rem != 16'd0) rem <= rem - 16'd1;
          end
          S_COLLECT: begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
              if (byte_idx == IDX_W'(b)) m_word_o[b*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
            end
            if (rem != 16'd0) rem <= rem - 16'd1;
            if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
              byte_idx <= '0;
              m_last_o <= (rem == 16'd1);
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
      if (state == S_OUT && m_ready_i) m_first_o <= 1'b0;
    end
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_run;
  logic              idle_clr;

  // The counter is frozen (neither runs nor clears) while a downstream port is holding us off.
  always_comb begin
    idle_run = 1'b0;
    idle_clr = 1'b0;
    if (state inside {S_RESERVED, S_LEN_LSB, S_LEN_MSB, S_COLLECT, S_DRAIN} ||
        (state == S_ECHO && echo_tready_i)) begin
      idle_run = !s_axis_tvalid;
      idle_clr = s_axis_tvalid;
    end
  end

  assign timeout = idle_run && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || state == S_OPCODE || idle_clr || timeout) begin
      idle_cnt <= '0;
    end else if (idle_run) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule
